// File: rtl/fp16_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : fp16_multiplier
// Purpose  : IEEE-754 binary16 multiplier, RNE rounding, DAZ/FTZ, one output
//            register stage with exception/overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_multiplier #(
    parameter int DWIDTH = 16,
    parameter int EWIDTH = 5,
    parameter int MWIDTH = 10,
    parameter int BIAS   = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] a_operand,
    input  logic [DWIDTH-1:0] b_operand,
    output logic [DWIDTH-1:0] result,
    output logic              Exception,
    output logic              Overflow,
    output logic              Underflow
);

    localparam int PW   = 2 * MWIDTH + 2;
    localparam int EXW  = EWIDTH + 3;
    localparam int EMAX = (1 << EWIDTH) - 1;

    logic              sign;
    logic [EWIDTH-1:0] ea, eb;
    logic [MWIDTH-1:0] fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [PW-1:0]     prod;
    logic [MWIDTH-1:0] mant;
    logic              guard, sticky, round_up;
    logic [MWIDTH:0]   mant_rnd;
    logic [EXW-1:0]    exp_norm;
    logic signed [EXW-1:0] exp_fin;
    logic [MWIDTH-1:0] frac_fin;

    logic [DWIDTH-1:0] result_d, result_q;
    logic              exc_d, exc_q, ovf_d, ovf_q, unf_d, unf_q;

    assign sign   = a_operand[DWIDTH-1] ^ b_operand[DWIDTH-1];
    assign ea     = a_operand[DWIDTH-2 -: EWIDTH];
    assign eb     = b_operand[DWIDTH-2 -: EWIDTH];
    assign fa     = a_operand[MWIDTH-1:0];
    assign fb     = b_operand[MWIDTH-1:0];
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    // Subnormal operands are taken as zero, so only the exponent matters here.
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);

    assign prod = {1'b1, fa} * {1'b1, fb};

    always_comb begin
        if (prod[PW-1]) begin
            mant   = prod[PW-2 -: MWIDTH];
            guard  = prod[PW-2-MWIDTH];
            sticky = |prod[PW-3-MWIDTH:0];
        end else begin
            mant   = prod[PW-3 -: MWIDTH];
            guard  = prod[PW-3-MWIDTH];
            sticky = |prod[PW-4-MWIDTH:0];
        end
    end

    assign round_up = guard & (sticky | mant[0]);
    assign mant_rnd = {1'b0, mant} + (MWIDTH+1)'(round_up);
    assign exp_norm = EXW'(ea) + EXW'(eb) + EXW'(prod[PW-1]) - EXW'(BIAS);
    assign exp_fin  = $signed(exp_norm + EXW'(mant_rnd[MWIDTH]));
    assign frac_fin = mant_rnd[MWIDTH] ? '0 : mant_rnd[MWIDTH-1:0];

    always_comb begin
        result_d = '0;
        exc_d    = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result_d = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(MWIDTH-1){1'b0}}};
            exc_d    = 1'b1;
        end else if (a_inf || b_inf) begin
            result_d = {sign, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
            exc_d    = 1'b1;
        end else if (a_zero || b_zero) begin
            result_d = {sign, {(DWIDTH-1){1'b0}}};
        end else if (exp_fin >= $signed(EXW'(EMAX))) begin
            result_d = {sign, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
            ovf_d    = 1'b1;
        end else if (exp_fin <= $signed(EXW'(0))) begin
            result_d = {sign, {(DWIDTH-1){1'b0}}};
            unf_d    = 1'b1;
        end else begin
            result_d = {sign, exp_fin[EWIDTH-1:0], frac_fin};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result_q <= '0;
            exc_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            exc_q    <= exc_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign result    = result_q;
    assign Exception = exc_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_multiplier
// Purpose  : Scoreboard bench for fp16_multiplier against a real-valued model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_multiplier;

    typedef struct packed {
        logic [15:0] r;
        logic        exc;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] result;
    logic        Exception, Overflow, Underflow;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp16_multiplier dut (
        .clk       (clk),
        .rstn      (rstn),
        .a_operand (a),
        .b_operand (b),
        .result    (result),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        exp_t o;
        logic s;
        int   ex, ey, fx, fy, fl, ee, be;
        bit   xn, yn, xi, yi, xz, yz;
        real  p, sc, fr;
        s  = x[15] ^ y[15];
        ex = int'(x[14:10]); ey = int'(y[14:10]);
        fx = int'(x[9:0]);   fy = int'(y[9:0]);
        xn = (ex == 31) && (fx != 0); yn = (ey == 31) && (fy != 0);
        xi = (ex == 31) && (fx == 0); yi = (ey == 31) && (fy == 0);
        xz = (ex == 0);               yz = (ey == 0);
        o = '0;
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            o.r = 16'h7E00; o.exc = 1'b1;
        end else if (xi || yi) begin
            o.r = {s, 5'h1F, 10'h0}; o.exc = 1'b1;
        end else if (xz || yz) begin
            o.r = {s, 15'h0};
        end else begin
            // value = p * 2^ee with p in [1,4); products of 11-bit ints are exact in a real
            p  = real'(1024 + fx) * real'(1024 + fy) / 1048576.0;
            ee = ex + ey - 30;
            if (p >= 2.0) begin p = p / 2.0; ee++; end
            sc = p * 1024.0;
            fl = $rtoi(sc);
            fr = sc - real'(fl);
            if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
            if (fl == 2048) begin fl = 1024; ee++; end
            be = ee + 15;
            if (be >= 31) begin
                o.r = {s, 5'h1F, 10'h0}; o.ovf = 1'b1;
            end else if (be <= 0) begin
                o.r = {s, 15'h0}; o.unf = 1'b1;
            end else begin
                o.r = {s, be[4:0], fl[9:0]};
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got r=%h exc=%b ovf=%b unf=%b, want r=%h exc=%b ovf=%b unf=%b (a=%h b=%h)",
                     name, got.r, got.exc, got.ovf, got.unf,
                     want.r, want.exc, want.ovf, want.unf, a, b);
        end
    endtask

    task automatic apply_exp(input logic [15:0] x, input logic [15:0] y, input exp_t want);
        @(negedge clk);
        a = x;
        b = y;
        sb_q.push_back(want);
    endtask

    task automatic apply_rand(input logic [15:0] x, input logic [15:0] y);
        apply_exp(x, y, model(x, y));
    endtask

    // Monitor: every rising edge presents the product of the operands applied
    // in the preceding half cycle.
    initial begin
        exp_t w;
        forever begin
            @(posedge clk);
            #1;
            if (rstn && sb_q.size() > 0) begin
                w = sb_q.pop_front();
                check("product", {result, Exception, Overflow, Underflow}, w);
            end
        end
    end

    initial begin
        logic [15:0] x, y;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {result, Exception, Overflow, Underflow}, '0);
        @(negedge clk);
        rstn = 1'b1;

        apply_exp(16'h5718, 16'hCB40, {16'hE66E, 3'b000});
        apply_exp(16'h475F, 16'h6A75, {16'h75F3, 3'b000});
        apply_exp(16'h3C00, 16'hC000, {16'hC000, 3'b000});
        apply_exp(16'h0000, 16'h7C00, {16'h7E00, 3'b100});
        apply_exp(16'h7800, 16'h7800, {16'h7C00, 3'b010});
        apply_exp(16'h0400, 16'h0400, {16'h0000, 3'b001});
        apply_exp(16'h3C01, 16'h3C01, {16'h3C02, 3'b000});
        apply_exp(16'h7E00, 16'h3C00, {16'h7E00, 3'b100});
        apply_exp(16'h7C00, 16'hBC00, {16'hFC00, 3'b100});
        apply_exp(16'h8000, 16'h3C00, {16'h8000, 3'b000});
        apply_exp(16'h0001, 16'h3C00, {16'h0000, 3'b000});
        apply_exp(16'hFBFF, 16'h3C00, {16'hFBFF, 3'b000});

        for (int i = 0; i < 300; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            apply_rand(x, y);
        end
        // Exponents concentrated near the overflow/underflow boundaries.
        for (int i = 0; i < 200; i++) begin
            x = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            if (i % 2 == 0)
                y = {1'($urandom), 5'($urandom_range(23, 30) - int'(x[14:10]) + 15), 10'($urandom)};
            else
                y = {1'($urandom), 5'($urandom_range(1, 16)), 10'($urandom)};
            if (y[14:10] == 5'd0) y[14:10] = 5'd1;
            if (y[14:10] == 5'd31) y[14:10] = 5'd30;
            apply_rand(x, y);
        end

        repeat (2) @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
            sb_q.delete();
        end

        // Asynchronous reset clearing a live non-zero product.
        @(negedge clk);
        a = 16'h3C00;
        b = 16'hC000;
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("async_reset", {result, Exception, Overflow, Underflow}, '0);
        @(posedge clk);
        #1;
        check("held_reset", {result, Exception, Overflow, Underflow}, '0);
        @(negedge clk);
        rstn = 1'b1;
        a = 16'h7800;
        b = 16'h7800;
        sb_q.push_back({16'h7C00, 3'b010});

        repeat (3) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL final_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
